dmem_responder: RTL and testbench

- Responder end of the CPU data-memory port. The pipelined MIPS core's MEM stage issues load/store requests; this block accepts them, applies a fixed, parameterised number of wait states, and returns one response per request.
- Wait states let the core's stall logic be exercised under non-zero memory latency.
- Sits between the core's MEM stage and a word-organised RAM array that this block owns.

---
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: accepts one load/store at a time,
// inserts WAIT_CYCLES wait states, then returns a single-cycle response from an owned RAM.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    state_t                state;
    logic [3:0]            cnt;
    req_t                  lat_req;
    req_t                  cur_req;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            low_lane;
    logic                  be_ok;
    logic                  lane_ok;
    logic                  range_ok;
    logic                  err;
    logic                  enter_resp;
    logic                  do_write;

    assign req_ready = (state == IDLE);

    // With zero wait states RESP is entered on the acceptance edge itself, so the
    // live request is checked there; otherwise the latched copy is used.
    always_comb begin
        cur_req = lat_req;
        if (state == IDLE) begin
            cur_req = {req_we, req_addr, req_be, req_wdata};
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        be_ok    = 1'b1;
        low_lane = 2'd0;
        case (cur_req.be)
            4'b0001: low_lane = 2'd0;
            4'b0010: low_lane = 2'd1;
            4'b0100: low_lane = 2'd2;
            4'b1000: low_lane = 2'd3;
            4'b0011: low_lane = 2'd0;
            4'b1100: low_lane = 2'd2;
            4'b1111: low_lane = 2'd0;
            default: be_ok    = 1'b0;
        endcase
    end

    assign offset     = cur_req.addr - BASE_ADDR;
    assign idx        = offset[ADDR_WIDTH+1:2];
    assign lane_ok    = (low_lane == cur_req.addr[1:0]);
    assign range_ok   = (cur_req.addr >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
    assign err        = !(be_ok && lane_ok && range_ok);
    assign enter_resp = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0));
    assign do_write   = enter_resp && cur_req.we && !err;

    // NOTE: the RAM array is deliberately left out of reset; clearing every word
    // would need a sweep, and stores in flight are dropped simply by never reaching RESP.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_req.be[i]) begin
                    mem[idx][8*i +: 8] <= cur_req.wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every branch
    // sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_req   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;

            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (!err && !cur_req.we) ? mem[idx] : 32'd0;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_req <= cur_req;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized loads/stores
// compared against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned AW   = 10;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned W    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_ready0, req_we0 = 1'b0;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic [3:0]  req_be0 = 4'hf;
    logic        rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [int];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_be(req_be0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    function automatic logic model_err(input logic [31:0] addr, input logic [3:0] be);
        int    lowest = -1;
        longint off;
        if (!(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}))
            return 1'b1;
        for (int i = 3; i >= 0; i--) if (be[i]) lowest = i;
        if (lowest != int'(addr[1:0])) return 1'b1;
        off = longint'({32'd0, addr}) - longint'({32'd0, BASE});
        if (off < 0 || (off / 4) >= longint'(2 ** AW)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int idx = int'((addr - BASE) / 4);
        return model_mem.exists(idx) ? model_mem[idx] : 32'd0;
    endfunction

    // Applies a transaction to the model; returns the expected response.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, output logic [31:0] exp_rdata,
                               output logic exp_err);
        logic [31:0] word;
        exp_err   = model_err(addr, be);
        exp_rdata = 32'd0;
        if (!exp_err) begin
            word = model_word(addr);
            if (we) begin
                for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
                model_mem[int'((addr - BASE) / 4)] = word;
            end else begin
                exp_rdata = word;
            end
        end
    endtask

    // Drives one transaction into the W-wait-state DUT and checks handshake, latency and pulse width.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int lat = 0;
        rdata = 'x;
        err   = 1'bx;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_before_req: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = $urandom_range(0, 1); req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
        for (int i = 0; i < 20 && lat == 0; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat   = i + 1;
                rdata = rsp_rdata;
                err   = rsp_err;
            end
        end
        total++;
        if (lat != int'(W) + 1) begin
            bad++;
            $display("FAIL latency: got %0d edges want %0d (0 = timeout)", lat, W + 1);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL pulse_width: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic run_and_check(input string name, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        logic [31:0] got_rdata, exp_rdata;
        logic        got_err, exp_err;
        model_apply(we, addr, be, wdata, exp_rdata, exp_err);
        do_txn(we, addr, be, wdata, got_rdata, got_err);
        total++;
        if (got_rdata !== exp_rdata || got_err !== exp_err) begin
            bad++;
            $display("FAIL %s: addr=%h be=%b we=%b got rdata=%h err=%b want rdata=%h err=%b",
                     name, addr, be, we, got_rdata, got_err, exp_rdata, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_and_check("store_word", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
        run_and_check("load_word", 1'b0, 32'h10, 4'b1111, 32'h0);
        run_and_check("store_byte", 1'b1, 32'h12, 4'b0100, 32'h00AB0000);
        run_and_check("load_after_byte", 1'b0, 32'h10, 4'b1111, 32'h0);
        total++;
        if (model_word(32'h10) !== 32'hDEABBEEF) begin
            bad++;
            $display("FAIL model_merge: got %h want DEABBEEF", model_word(32'h10));
        end
        run_and_check("misaligned_half", 1'b1, 32'h11, 4'b0011, 32'h0000CAFE);
        run_and_check("load_unchanged", 1'b0, 32'h10, 4'b1111, 32'h0);
        run_and_check("out_of_range", 1'b0, 32'h1000, 4'b1111, 32'h0);
        run_and_check("illegal_be", 1'b0, 32'h10, 4'b0101, 32'h0);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'b1111; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_mid_pulse: got %0d pulses want 0", pulses);
        end
        run_and_check("load_after_reset", 1'b0, 32'h20, 4'b1111, 32'h0);
    endtask

    task automatic test_back_to_back();
        int responses = 0;
        @(negedge clk);
        req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h0; req_be0 = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (req_ready0 !== ((i % 2) == 0) || rsp_valid0 !== ((i % 2) == 1)) begin
                bad++;
                $display("FAIL b2b_cycle%0d: ready=%b valid=%b want %b/%b",
                         i, req_ready0, rsp_valid0, (i % 2) == 0, (i % 2) == 1);
            end
            if (rsp_valid0 === 1'b1) responses++;
            @(negedge clk);
        end
        req_valid0 = 1'b0;
        total++;
        if (responses != 5) begin
            bad++;
            $display("FAIL b2b_count: got %0d responses want 5", responses);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [3:0]  be;
        logic [3:0]  legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) != 0) be = legal[$urandom_range(0, 6)];
            else                           be = 4'($urandom);
            addr = {20'd0, 10'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 9) == 0) addr = 32'h1000 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) begin
                addr[1:0] = 2'd0;
                for (int i = 3; i >= 0; i--) if (be[i]) addr[1:0] = 2'(i);
            end
            run_and_check("random", 1'($urandom_range(0, 1)), addr, be, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
